// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Dual-issue fetch: two 4-byte slots per fetch group.
// No logic here; imported by fetch_pc_ctrl and redirect_arb.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        REDIR = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_JAL  = 2'd1,
        SRC_JALR = 2'd2
    } redir_src_e;

    localparam int FETCH_WIDTH = 2;
    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_pc_ctrl_redirect_arb.sv
// Priority select of redirect source (execute JALR/branch over decode JAL).
// Latency: purely combinational, zero cycles.
// Backpressure: none; busy is handled by the caller's FSM.
module redirect_arb
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            jal,
    input  logic [XLEN-1:0] jal_addr,
    input  logic            jalr_jcond,
    input  logic [XLEN-1:0] jalr_jcond_addr,
    output redir_src_e      src,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic [XLEN-1:0] raw_target;

    always_comb begin
        src        = SRC_NONE;
        raw_target = '0;
        // The older instruction (execute stage) wins; a coincident JAL is on the wrong path.
        if (jalr_jcond) begin
            src        = SRC_JALR;
            raw_target = jalr_jcond_addr;
        end else if (jal) begin
            src        = SRC_JAL;
            raw_target = jal_addr;
        end
    end

    assign target   = {raw_target[XLEN-1:2], 2'b00};
    assign misalign = (src != SRC_NONE) && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Next-PC sequencer for dual-issue fetch; optional counters under FETCH_PERF_CNT_EN.
// Latency: redirect -> valid fetch at target in 2 cycles; busy drop -> valid fetch in 1 cycle.
// Backpressure: busy holds fetch_pc (STALL); slots shown while busy are re-presented later.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jal,
    input  logic [XLEN-1:0] jal_addr,
    input  logic            jalr_jcond,
    input  logic [XLEN-1:0] jalr_jcond_addr,
    input  logic            busy,
    output logic [XLEN-1:0] fetch_pc,
    output logic [1:0]      fetch_valid,
    output logic            flush_decode,
    output logic            flush_issue,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     redirect_cnt,
    output logic [31:0]     stall_cnt,
`endif
    output logic            misalign
);

    localparam logic [XLEN-1:0] STEP_ONE  = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP_FULL = XLEN'(FETCH_WIDTH * INSTR_BYTES);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            flush_decode_nxt, flush_issue_nxt, misalign_nxt;

    redir_src_e      redir_src;
    logic [XLEN-1:0] redir_target;
    logic            redir_misalign;
    logic            redir_take;

    redirect_arb #(.XLEN(XLEN)) u_redirect_arb (
        .jal             (jal),
        .jal_addr        (jal_addr),
        .jalr_jcond      (jalr_jcond),
        .jalr_jcond_addr (jalr_jcond_addr),
        .src             (redir_src),
        .target          (redir_target),
        .misalign        (redir_misalign)
    );

    assign redir_take = (redir_src != SRC_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            fetch_pc     <= XLEN'(RESET_PC);
            flush_decode <= 1'b0;
            flush_issue  <= 1'b0;
            misalign     <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_pc     <= pc_nxt;
            flush_decode <= flush_decode_nxt;
            flush_issue  <= flush_issue_nxt;
            misalign     <= misalign_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        pc_nxt           = fetch_pc;
        flush_decode_nxt = 1'b0;
        flush_issue_nxt  = 1'b0;
        misalign_nxt     = 1'b0;
        if (redir_take) begin
            state_nxt        = REDIR;
            pc_nxt           = redir_target;
            flush_decode_nxt = 1'b1;
            flush_issue_nxt  = (redir_src == SRC_JALR);
            misalign_nxt     = redir_misalign;
        end else begin
            unique case (state)
                BOOT:  state_nxt = RUN;
                RUN: begin
                    if (busy) begin
                        state_nxt = STALL;
                    end else begin
                        // A group starting at pc[2]=1 only carries one slot, so realign to 8 bytes.
                        pc_nxt = fetch_pc + (fetch_pc[2] ? STEP_ONE : STEP_FULL);
                    end
                end
                STALL: state_nxt = busy ? STALL : RUN;
                REDIR: state_nxt = busy ? STALL : RUN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    assign fetch_valid = (state == RUN) ? {~fetch_pc[2], 1'b1} : 2'b00;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redir_take && (redirect_cnt != 32'hFFFF_FFFF)) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
            if ((state == STALL) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: sequential fetch, redirects, stalls, wrap, reset.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jal;
    logic [31:0] jal_addr;
    logic        jalr_jcond;
    logic [31:0] jalr_jcond_addr;
    logic        busy;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_valid;
    logic        flush_decode;
    logic        flush_issue;
    logic        misalign;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .jal             (jal),
        .jal_addr        (jal_addr),
        .jalr_jcond      (jalr_jcond),
        .jalr_jcond_addr (jalr_jcond_addr),
        .busy            (busy),
        .fetch_pc        (fetch_pc),
        .fetch_valid     (fetch_valid),
        .flush_decode    (flush_decode),
        .flush_issue     (flush_issue),
`ifdef FETCH_PERF_CNT_EN
        .redirect_cnt    (redirect_cnt),
        .stall_cnt       (stall_cnt),
`endif
        .misalign        (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Advance one edge; outputs are sampled 1ns later, and inputs changed after this return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [31:0] pc, input logic [1:0] fv,
                              input logic fd, input logic fi, input logic mis);
        chk({tag, ".pc"}, fetch_pc, pc);
        chk({tag, ".fv"}, {30'd0, fetch_valid}, {30'd0, fv});
        chk({tag, ".fd"}, {31'd0, flush_decode}, {31'd0, fd});
        chk({tag, ".fi"}, {31'd0, flush_issue}, {31'd0, fi});
        chk({tag, ".mis"}, {31'd0, misalign}, {31'd0, mis});
    endtask

    initial begin
        rst = 1'b1; jal = 1'b0; jal_addr = '0; jalr_jcond = 1'b0; jalr_jcond_addr = '0; busy = 1'b0;
        step(); step();
        expect_all("reset", 32'h0, 2'b00, 0, 0, 0);
        rst = 1'b0;

        step(); expect_all("boot_exit", 32'h0, 2'b11, 0, 0, 0);
        step(); expect_all("seq8", 32'h8, 2'b11, 0, 0, 0);
        step(); expect_all("seq10", 32'h10, 2'b11, 0, 0, 0);

        // JAL redirect
        jal = 1'b1; jal_addr = 32'h10;
        step(); expect_all("jal_redir", 32'h10, 2'b00, 1, 0, 0);
        jal = 1'b0;
        step(); expect_all("jal_run", 32'h10, 2'b11, 0, 0, 0);

        // Simultaneous: execute-stage redirect wins
        jal = 1'b1; jal_addr = 32'h10; jalr_jcond = 1'b1; jalr_jcond_addr = 32'h24;
        step(); expect_all("both_redir", 32'h24, 2'b00, 1, 1, 0);
        jal = 1'b0; jalr_jcond = 1'b0;
        step(); expect_all("both_run24", 32'h24, 2'b01, 0, 0, 0);
        step(); expect_all("both_run28", 32'h28, 2'b11, 0, 0, 0);

        // Misaligned target
        jal = 1'b1; jal_addr = 32'h0A;
        step(); expect_all("mis_redir", 32'h08, 2'b00, 1, 0, 1);
        jal = 1'b0;
        step(); expect_all("mis_run", 32'h08, 2'b11, 0, 0, 0);

        // Busy for three edges at 0x40
        jal = 1'b1; jal_addr = 32'h40;
        step(); jal = 1'b0;
        step(); expect_all("b40_run", 32'h40, 2'b11, 0, 0, 0);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_all($sformatf("stall%0d", i), 32'h40, 2'b00, 0, 0, 0);
        end
        busy = 1'b0;
        step(); expect_all("stall_exit", 32'h40, 2'b11, 0, 0, 0);
        step(); expect_all("stall_adv", 32'h48, 2'b11, 0, 0, 0);

        // Redirect while busy
        jal = 1'b1; jal_addr = 32'h20; busy = 1'b1;
        step(); expect_all("rb_redir", 32'h20, 2'b00, 1, 0, 0);
        jal = 1'b0;
        step(); expect_all("rb_stall0", 32'h20, 2'b00, 0, 0, 0);
        step(); expect_all("rb_stall1", 32'h20, 2'b00, 0, 0, 0);
        busy = 1'b0;
        step(); expect_all("rb_resume", 32'h20, 2'b11, 0, 0, 0);

        // Modulo wrap of the PC add
        jalr_jcond = 1'b1; jalr_jcond_addr = 32'hFFFF_FFF8;
        step(); expect_all("wrap_redir", 32'hFFFF_FFF8, 2'b00, 1, 1, 0);
        jalr_jcond = 1'b0;
        step(); expect_all("wrap_top", 32'hFFFF_FFF8, 2'b11, 0, 0, 0);
        step(); expect_all("wrap_zero", 32'h0, 2'b11, 0, 0, 0);

        // Redirect back-to-back: REDIR re-enters REDIR
        jal = 1'b1; jal_addr = 32'h100;
        step(); expect_all("rr_first", 32'h100, 2'b00, 1, 0, 0);
        jal = 1'b0; jalr_jcond = 1'b1; jalr_jcond_addr = 32'h203;
        step(); expect_all("rr_second", 32'h200, 2'b00, 1, 1, 1);
        jalr_jcond = 1'b0;
        step(); expect_all("rr_run", 32'h200, 2'b11, 0, 0, 0);

        // Reset during REDIR overrides a concurrent redirect
        jalr_jcond = 1'b1; jalr_jcond_addr = 32'h80;
        step(); expect_all("rst_pre", 32'h80, 2'b00, 1, 1, 0);
        jalr_jcond = 1'b0; rst = 1'b1; jal = 1'b1; jal_addr = 32'h44;
        step(); expect_all("rst_mid", 32'h0, 2'b00, 0, 0, 0);
        rst = 1'b0; jal = 1'b0;
        step(); expect_all("rst_boot_exit", 32'h0, 2'b11, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
